// File: rtl/immediate_gen_stage.sv
// immediate_gen_stage: registered RV32I/RV64I immediate generator behind a 2-entry skid buffer
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   flush                   synchronous flush, empties the buffer
//   in_valid/in_ready       upstream handshake (in_ready is registered-state only)
//   in_instr, in_imm_src    instruction word and format select
//   out_valid/out_ready     downstream handshake
//   out_imm, out_err        head-entry immediate and malformed flag
// Build option: define IMM_CHECK_EN to store and report per-entry error bits.
module immediate_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
`ifdef IMM_CHECK_EN
    localparam int EW = XLEN + 1;
`else
    localparam int EW = XLEN;
`endif
    state_e          state_q, state_d;
    logic [EW-1:0]   head_q, head_d, tail_q, tail_d, new_entry;
    logic [31:0]     i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm_new;
    logic            push, pop, unused_opcode;
    assign unused_opcode = ^in_instr[6:0];
    assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
    assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign b_imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign u_imm = {in_instr[31:12], 12'b0};
    assign j_imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    // 32-bit sign-extended forms are widened by a signed cast, a no-op for XLEN=32
    assign imm_new = in_imm_src == 3'b000 ? XLEN'($signed(i_imm)) :
                     in_imm_src == 3'b001 ? XLEN'(shamt) :
                     in_imm_src == 3'b010 ? XLEN'($signed(s_imm)) :
                     in_imm_src == 3'b011 ? XLEN'($signed(b_imm)) :
                     in_imm_src == 3'b100 ? XLEN'($signed(u_imm)) :
                     in_imm_src == 3'b101 ? XLEN'($signed(j_imm)) :
                     in_imm_src == 3'b110 ? XLEN'(in_instr[19:15]) : '0;
`ifdef IMM_CHECK_EN
    logic err_new;
    // branch/jump offsets must be 4-byte aligned: no compressed support
    assign err_new = (in_imm_src == 3'b111) ||
                     (in_imm_src == 3'b001 && XLEN == 32 && in_instr[25]) ||
                     ((in_imm_src == 3'b011 || in_imm_src == 3'b101) && imm_new[1]);
    assign new_entry = {err_new, imm_new};
    assign out_err   = head_q[XLEN];
`else
    assign new_entry = imm_new;
    assign out_err   = 1'b0;
`endif
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_imm   = head_q[XLEN-1:0];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: if (push) begin
                state_d = ONE;
                head_d  = new_entry;
            end
            ONE: if (push && pop) begin
                head_d = new_entry;
            end else if (push) begin
                state_d = FULL;
                tail_d  = new_entry;
            end else if (pop) begin
                state_d = EMPTY;
            end
            FULL: if (pop) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
endmodule

// File: tb/tb_immediate_gen_stage.sv
// tb_immediate_gen_stage: directed-vector bench driving an XLEN=32 and an XLEN=64 instance in lockstep
module tb_immediate_gen_stage;
`ifdef IMM_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    logic        clk, reset_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic        rdy32, v32, err32, rdy64, v64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    int          n_vec = 0;
    int          n_err = 0;

    immediate_gen_stage #(.XLEN(32)) u32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_err(err32)
    );
    immediate_gen_stage #(.XLEN(64)) u64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_err(err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one accept with out_ready=1, entry must be at the head right after the edge
    task automatic vec(input string tag, input logic [31:0] ins, input logic [2:0] src,
                       input logic [63:0] e32, input logic [63:0] e64, input logic r32, input logic r64);
        in_valid   = 1'b1;
        in_instr   = ins;
        in_imm_src = src;
        tick();
        chk({tag, "_v32"}, 64'(v32), 64'd1);
        chk({tag, "_imm32"}, 64'(imm32), e32);
        chk({tag, "_err32"}, 64'(err32), 64'(r32 & CHK));
        chk({tag, "_v64"}, 64'(v64), 64'd1);
        chk({tag, "_imm64"}, imm64, e64);
        chk({tag, "_err64"}, 64'(err64), 64'(r64 & CHK));
    endtask

    initial begin
        flush = 0; in_valid = 0; out_ready = 1; in_instr = 0; in_imm_src = 0; reset_n = 1;
        #1 reset_n = 0;
        #3;
        chk("rst_rdy", 64'(rdy32), 64'd1);
        chk("rst_v", 64'(v32), 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_err32", 64'(err32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_v64", 64'(v64), 64'd0);
        tick();
        reset_n = 1;
        vec("i_addi",  32'hFFF00093, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 0);
        vec("s_sw",    32'hFE112E23, 3'd2, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0, 0);
        vec("j_jal",   32'hFFDFF06F, 3'd5, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0, 0);
        vec("b_beq",   32'hFE000EE3, 3'd3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0, 0);
        vec("b_odd",   32'hFE000FE3, 3'd3, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1, 1);
        vec("u_neg",   32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000, 0, 0);
        vec("u_pos",   32'h12345037, 3'd4, 64'h12345000, 64'h0000000012345000, 0, 0);
        vec("sh_63",   32'h03F09093, 3'd1, 64'h1F, 64'h3F, 1, 0);
        vec("sh_31",   32'h01F09093, 3'd1, 64'h1F, 64'h1F, 0, 0);
        vec("sh_b25",  32'h02009093, 3'd1, 64'h0, 64'h20, 1, 0);
        vec("zimm",    32'h800F8073, 3'd6, 64'h1F, 64'h1F, 0, 0);
        vec("rsv",     32'hFFFFFFFF, 3'd7, 64'h0, 64'h0, 1, 1);
        vec("j_odd",   32'h0020006F, 3'd5, 64'h2, 64'h2, 1, 1);
        in_valid = 0;
        tick();
        chk("drain_v", 64'(v32), 64'd0);
        // backpressure: three accepts offered with out_ready low
        out_ready = 0; in_valid = 1; in_imm_src = 3'd0; in_instr = 32'h00100093;
        tick();
        chk("bp1_v", 64'(v32), 64'd1);
        chk("bp1_imm", 64'(imm32), 64'd1);
        chk("bp1_rdy", 64'(rdy32), 64'd1);
        in_instr = 32'h00200093;
        tick();
        chk("bp2_rdy", 64'(rdy32), 64'd0);
        chk("bp2_imm", 64'(imm32), 64'd1);
        in_instr = 32'h00300093;
        tick();
        chk("bp3_rdy", 64'(rdy32), 64'd0);
        chk("bp3_hold", 64'(imm32), 64'd1);
        chk("bp3_v", 64'(v32), 64'd1);
        out_ready = 1;
        tick();
        chk("bp_pop2", 64'(imm32), 64'd2);
        chk("bp_pop2_rdy", 64'(rdy32), 64'd1);
        tick();
        chk("bp_pop3", 64'(imm32), 64'd3);
        chk("bp_pop3_64", imm64, 64'd3);
        in_valid = 0;
        tick();
        chk("bp_empty", 64'(v32), 64'd0);
        // flush while FULL with a pending offer
        out_ready = 0; in_valid = 1; in_instr = 32'h00500093;
        tick();
        in_instr = 32'h00600093;
        tick();
        chk("fl_full", 64'(rdy32), 64'd0);
        in_instr = 32'h00700093; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("fl_v", 64'(v32), 64'd0);
        chk("fl_rdy", 64'(rdy32), 64'd1);
        out_ready = 1;
        repeat (3) tick();
        chk("fl_gone", 64'(v32), 64'd0);
        // flush beats a same-cycle push and pop
        in_valid = 1; in_instr = 32'h00800093;
        tick();
        chk("fl1_imm", 64'(imm32), 64'd8);
        in_instr = 32'h00900093; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("fl1_v", 64'(v32), 64'd0);
        tick();
        chk("fl1_gone", 64'(v32), 64'd0);
        // asynchronous reset mid-operation
        out_ready = 0; in_valid = 1; in_instr = 32'h00A00093;
        tick();
        in_valid = 0;
        chk("ar_pre", 64'(imm32), 64'hA);
        #2 reset_n = 0;
        #1;
        chk("ar_v", 64'(v32), 64'd0);
        chk("ar_imm", 64'(imm32), 64'd0);
        chk("ar_rdy", 64'(rdy32), 64'd1);
        tick();
        reset_n = 1;
        tick();
        chk("ar_after", 64'(v32), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
